qoa_lms_predictor: RTL and testbench

//  Reconstruction stage directly downstream of the dequantiser lookup: takes one signed dequantised

---
 rtl/qoa_pkg.sv | 49 ++++
 rtl/qoa_lms_predictor_if.sv | 35 +++
 rtl/qoa_sat16.sv | 30 +++
 rtl/qoa_lms_predictor.sv | 181 ++++++++++++++++++
 tb/tb_qoa_lms_predictor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qoa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qoa_pkg
// Description : Shared constants, types and helpers for the QOA decoder
//               datapath (LMS predictor, saturator, later stereo/mix stages).
// Revision    : 1.0 - initial release
// ============================================================================
package qoa_pkg;

    localparam int QOA_ORDER       = 4;   // LMS taps
    localparam int QOA_SAMPLE_W    = 16;  // sample / history / weight / dq width
    localparam int QOA_PRED_SHIFT  = 13;  // dot-product scaling
    localparam int QOA_DELTA_SHIFT = 4;   // dq -> weight delta scaling
    localparam int QOA_PROD_W      = 2 * QOA_SAMPLE_W;
    // 4 products of up to 2^30 magnitude sum without wrapping in 34 bits
    localparam int QOA_ACC_W       = QOA_PROD_W + 2;

    localparam logic signed [QOA_SAMPLE_W-1:0] S16_MAX = 16'sh7FFF;
    localparam logic signed [QOA_SAMPLE_W-1:0] S16_MIN = 16'sh8000;

    // lms_load_idx map: 0-3 history taps, 4-7 weight taps
    localparam logic [2:0] LMS_IDX_HIST0 = 3'd0;
    localparam logic [2:0] LMS_IDX_W0    = 3'd4;

    typedef logic signed [QOA_SAMPLE_W-1:0] s16_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MAC     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUT     = 2'd3
    } qoa_state_t;

    // Signed 16x16 -> 32 product
    function automatic logic signed [QOA_PROD_W-1:0] mul_s16(input s16_t a, input s16_t b);
        logic signed [QOA_PROD_W-1:0] a_ext;
        logic signed [QOA_PROD_W-1:0] b_ext;
        a_ext = {{QOA_SAMPLE_W{a[QOA_SAMPLE_W-1]}}, a};
        b_ext = {{QOA_SAMPLE_W{b[QOA_SAMPLE_W-1]}}, b};
        return a_ext * b_ext;
    endfunction

    // Sign-extend a product to accumulator width
    function automatic logic signed [QOA_ACC_W-1:0] sext_prod(input logic signed [QOA_PROD_W-1:0] p);
        return {{(QOA_ACC_W-QOA_PROD_W){p[QOA_PROD_W-1]}}, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qoa_lms_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : qoa_lms_predictor_if
// Description : Handshake bundle of the LMS predictor: residual input,
//               header-state load port and PCM sample output.
//               slave  : predictor side
//               master : upstream/downstream (parser, dequantiser, consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface qoa_lms_predictor_if;
    import qoa_pkg::*;

    logic       dq_valid;
    logic       dq_ready;
    s16_t       dq_data;
    logic       lms_load_valid;
    logic       lms_load_ready;
    logic [2:0] lms_load_idx;
    s16_t       lms_load_data;
    logic       out_valid;
    logic       out_ready;
    s16_t       out_sample;

    modport slave (
        input  dq_valid, dq_data, lms_load_valid, lms_load_idx, lms_load_data, out_ready,
        output dq_ready, lms_load_ready, out_valid, out_sample
    );

    modport master (
        output dq_valid, dq_data, lms_load_valid, lms_load_idx, lms_load_data, out_ready,
        input  dq_ready, lms_load_ready, out_valid, out_sample
    );

endinterface
`default_nettype wire

// File: rtl/qoa_sat16.sv
`default_nettype none
// ============================================================================
// Module      : qoa_sat16
// Description : Combinational saturator, 34-bit signed -> 16-bit signed.
//               Shared with the stereo/mix stages.
// Ports       : in_i  [33:0] signed input
//               out_o [15:0] input clamped to [-32768, 32767]
// Revision    : 1.0 - initial release
// ============================================================================
module qoa_sat16
    import qoa_pkg::*;
(
    input  logic signed [QOA_ACC_W-1:0]    in_i,
    output logic signed [QOA_SAMPLE_W-1:0] out_o
);

    // Value fits in 16 bits only if every bit above bit 15 equals the sign
    logic w_ovf;
    assign w_ovf = (in_i[QOA_ACC_W-1:QOA_SAMPLE_W-1] !=
                    {(QOA_ACC_W-QOA_SAMPLE_W+1){in_i[QOA_ACC_W-1]}});

    always_comb begin
        out_o = in_i[QOA_SAMPLE_W-1:0];
        if (w_ovf) begin
            out_o = in_i[QOA_ACC_W-1] ? S16_MIN : S16_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qoa_lms_predictor.sv
`default_nettype none
// ============================================================================
// Module      : qoa_lms_predictor
// Description : QOA reconstruction stage. Adds the 4-tap LMS prediction to
//               each dequantised residual, clamps to int16, emits the PCM
//               sample, then adapts the weights and shifts the history.
//               Holds one channel's LMS state, loaded from the frame header.
// Ports       : clk    clock
//               rst_n  asynchronous active-low reset
//               bus    qoa_lms_predictor_if.slave
//                      dq_*        residual in (valid/ready)
//                      lms_load_*  header write, idx 0-3 history, 4-7 weights
//                      out_*       PCM sample out (valid/ready)
// Config      : QOA_LMS_PARALLEL_MAC_EN - defined: full dot product in one
//               MAC cycle (handshake -> out_valid = 3 cycles). Undefined:
//               one shared multiplier, 4 MAC cycles (6 cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module qoa_lms_predictor
    import qoa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    qoa_lms_predictor_if.slave bus
);

    qoa_state_t state_q, state_d;

    s16_t                        hist_q [QOA_ORDER];
    s16_t                        w_q    [QOA_ORDER];
    s16_t                        dq_q;
    s16_t                        out_sample_q;
    logic signed [QOA_ACC_W-1:0] acc_q;

    logic                        w_dq_fire;
    logic                        w_load_fire;
    logic signed [QOA_ACC_W-1:0] w_mac_term;
    logic signed [QOA_ACC_W-1:0] w_pred;
    logic signed [QOA_ACC_W-1:0] w_dq_ext;
    logic signed [QOA_ACC_W-1:0] w_sum;
    s16_t                        w_sat;
    s16_t                        w_delta;

`ifdef QOA_LMS_PARALLEL_MAC_EN
    // All taps multiplied at once, summed in one adder tree
    logic signed [QOA_PROD_W-1:0] w_prod [QOA_ORDER];

    for (genvar g = 0; g < QOA_ORDER; g++) begin : g_mac
        assign w_prod[g] = mul_s16(hist_q[g], w_q[g]);
    end

    assign w_mac_term = (sext_prod(w_prod[0]) + sext_prod(w_prod[1])) +
                        (sext_prod(w_prod[2]) + sext_prod(w_prod[3]));
`else
    // Single multiplier walked over the taps by tap_q
    logic [1:0]                   tap_q;
    logic signed [QOA_PROD_W-1:0] w_prod;

    assign w_prod     = mul_s16(hist_q[tap_q], w_q[tap_q]);
    assign w_mac_term = sext_prod(w_prod);
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.dq_ready       = 1'b0;
        bus.lms_load_ready = 1'b0;
        bus.out_valid      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.lms_load_ready = 1'b1;
                // A header write in the same cycle takes priority over a residual
                bus.dq_ready       = !bus.lms_load_valid;
                if (bus.dq_valid && !bus.lms_load_valid) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
`ifdef QOA_LMS_PARALLEL_MAC_EN
                state_d = ST_RESOLVE;
`else
                if (tap_q == 2'(QOA_ORDER - 1)) begin
                    state_d = ST_RESOLVE;
                end
`endif
            end
            ST_RESOLVE: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_dq_fire   = bus.dq_valid && bus.dq_ready;
    assign w_load_fire = bus.lms_load_valid && bus.lms_load_ready;

    // ------------------------------------------------------ resolve math
    assign w_pred   = acc_q >>> QOA_PRED_SHIFT;
    assign w_dq_ext = {{(QOA_ACC_W-QOA_SAMPLE_W){dq_q[QOA_SAMPLE_W-1]}}, dq_q};
    assign w_sum    = w_pred + w_dq_ext;
    assign w_delta  = dq_q >>> QOA_DELTA_SHIFT;

    qoa_sat16 u_sat (
        .in_i  (w_sum),
        .out_o (w_sat)
    );

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            dq_q         <= '0;
            out_sample_q <= '0;
`ifndef QOA_LMS_PARALLEL_MAC_EN
            tap_q        <= '0;
`endif
            for (int i = 0; i < QOA_ORDER; i++) begin
                hist_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_load_fire) begin
                        if (bus.lms_load_idx >= LMS_IDX_W0) begin
                            w_q[bus.lms_load_idx[1:0]] <= bus.lms_load_data;
                        end else begin
                            hist_q[bus.lms_load_idx[1:0]] <= bus.lms_load_data;
                        end
                    end else if (w_dq_fire) begin
                        dq_q  <= bus.dq_data;
                        acc_q <= '0;
`ifndef QOA_LMS_PARALLEL_MAC_EN
                        tap_q <= '0;
`endif
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + w_mac_term;
`ifndef QOA_LMS_PARALLEL_MAC_EN
                    tap_q <= tap_q + 2'd1;
`endif
                end
                ST_RESOLVE: begin
                    out_sample_q <= w_sat;
                    // Sign-LMS update uses the history before it shifts; 16-bit wrap
                    for (int i = 0; i < QOA_ORDER; i++) begin
                        w_q[i] <= hist_q[i][QOA_SAMPLE_W-1] ? (w_q[i] - w_delta)
                                                            : (w_q[i] + w_delta);
                    end
                    for (int i = 0; i < QOA_ORDER - 1; i++) begin
                        hist_q[i] <= hist_q[i+1];
                    end
                    hist_q[QOA_ORDER-1] <= w_sat;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_sample = out_sample_q;

endmodule
`default_nettype wire

// File: tb/tb_qoa_lms_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_qoa_lms_predictor
// Description : Self-checking bench for qoa_lms_predictor. Directed residuals
//               with hand-computed samples pushed into a scoreboard queue; a
//               monitor pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qoa_lms_predictor;
    import qoa_pkg::*;

`ifdef QOA_LMS_PARALLEL_MAC_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 6;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    qoa_lms_predictor_if bus ();

    qoa_lms_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_xfer   = 0;
    int   exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the posedge following a negedge where
    // out_valid & out_ready are both seen.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", exp_q.size(), 1);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("sb_sample", int'(bus.out_sample), e);
            end
        end
    end

    task automatic load(input logic [2:0] idx, input int d);
        bit ok;
        ok = 1'b0;
        bus.lms_load_valid = 1'b1;
        bus.lms_load_idx   = idx;
        bus.lms_load_data  = 16'(d);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.lms_load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.lms_load_valid = 1'b0;
        if (!ok) check("load_timeout", 0, 1);
    endtask

    task automatic load_state(input int h0, input int h1, input int h2, input int h3,
                              input int w0, input int w1, input int w2, input int w3);
        load(3'd0, h0); load(3'd1, h1); load(3'd2, h2); load(3'd3, h3);
        load(3'd4, w0); load(3'd5, w1); load(3'd6, w2); load(3'd7, w3);
    endtask

    // Returns at posedge+1 just after the handshake edge (cycle 1)
    task automatic dq_send(input int d);
        bit ok;
        ok = 1'b0;
        bus.dq_valid = 1'b1;
        bus.dq_data  = 16'(d);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.dq_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.dq_valid = 1'b0;
        if (!ok) check("dq_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int bad;
        int x0;

        bus.dq_valid       = 1'b0;
        bus.dq_data        = '0;
        bus.lms_load_valid = 1'b0;
        bus.lms_load_idx   = '0;
        bus.lms_load_data  = '0;
        bus.out_ready      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid_low", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        #1;
        check("rst_dq_ready", int'(bus.dq_ready), 1);
        check("rst_load_ready", int'(bus.lms_load_ready), 1);
        check("rst_out_sample", int'(bus.out_sample), 0);
        @(posedge clk);
        #1;

        // 1: zero state
        exp_q.push_back(5);
        dq_send(5);
        wait_valid(lat);
        check("latency", lat, EXP_LAT);
        drain();
        check("t1_hist3", int'(dut.hist_q[3]), 5);
        check("t1_hist2", int'(dut.hist_q[2]), 0);
        for (int i = 0; i < 4; i++) check("t1_w", int'(dut.w_q[i]), 0);

        // 2: loaded state, weight adaptation
        load_state(0, 0, 0, 1000, 0, 0, -8192, 16384);
        exp_q.push_back(1853);
        dq_send(-147);
        drain();
        check("t2_w0", int'(dut.w_q[0]), -10);
        check("t2_w1", int'(dut.w_q[1]), -10);
        check("t2_w2", int'(dut.w_q[2]), -8202);
        check("t2_w3", int'(dut.w_q[3]), 16374);
        check("t2_hist2", int'(dut.hist_q[2]), 1000);
        check("t2_hist3", int'(dut.hist_q[3]), 1853);

        // 3: saturation both ways
        load_state(0, 0, 0, 30000, 0, 0, 0, 16384);
        exp_q.push_back(32767);
        dq_send(14336);
        drain();
        check("t3_hist3_pos", int'(dut.hist_q[3]), 32767);
        load_state(0, 0, 0, -30000, 0, 0, 0, 16384);
        exp_q.push_back(-32768);
        dq_send(-14336);
        drain();
        check("t3_hist3_neg", int'(dut.hist_q[3]), -32768);

        // 4: backpressure
        load_state(0, 0, 0, 100, 0, 0, 0, 8192);
        bus.out_ready = 1'b0;
        exp_q.push_back(120);
        dq_send(20);
        wait_valid(lat);
        check("bp_sample", int'(bus.out_sample), 120);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_sample != 16'sd120 || bus.dq_ready) bad++;
        end
        check("bp_stable_bad_cycles", bad, 0);
        x0 = n_xfer;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_transfers", n_xfer - x0, 1);
        check("bp_out_valid_after", int'(bus.out_valid), 0);
        check("bp_queue", exp_q.size(), 0);

        // 5: load refused outside IDLE, load beats dq in IDLE
        load_state(0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(9);
        dq_send(9);
        bus.lms_load_valid = 1'b1;
        bus.lms_load_idx   = 3'd4;
        bus.lms_load_data  = 16'sd1234;
        @(negedge clk);
        check("load_ready_busy", int'(bus.lms_load_ready), 0);
        @(posedge clk);
        #1;
        bus.lms_load_valid = 1'b0;
        drain();
        check("w0_untouched", int'(dut.w_q[0]), 0);

        bus.lms_load_valid = 1'b1;
        bus.lms_load_idx   = 3'd7;
        bus.lms_load_data  = 16'sd16384;
        bus.dq_valid       = 1'b1;
        bus.dq_data        = 16'sd12;
        @(negedge clk);
        check("dq_ready_blocked", int'(bus.dq_ready), 0);
        check("load_ready_idle", int'(bus.lms_load_ready), 1);
        @(posedge clk);
        #1;
        bus.lms_load_valid = 1'b0;
        check("simul_load_w3", int'(dut.w_q[3]), 16384);
        exp_q.push_back(30);   // (9*16384)>>>13 = 18, +12
        dq_send(12);
        drain();

        // 6: async reset mid-MAC
        dq_send(50);
        rst_n = 1'b0;
        #1;
        check("rstmac_out_valid", int'(bus.out_valid), 0);
        check("rstmac_acc_nonzero", int'(dut.acc_q != '0), 0);
        check("rstmac_hist3", int'(dut.hist_q[3]), 0);
        check("rstmac_w3", int'(dut.w_q[3]), 0);
        check("rstmac_out_sample", int'(bus.out_sample), 0);
        check("rstmac_dq_ready", int'(bus.dq_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(7);
        dq_send(7);
        wait_valid(lat);
        check("latency_after_reset", lat, EXP_LAT);
        drain();

        repeat (3) @(posedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
